wam_game_engine: RTL and testbench

- Parametrised whack-a-mole game core. Drives N mole lights in pseudo-random order and scores keypad hits against the lit mole.
- Supports four game modes and four difficulty levels.
- Sits between the top-level switch/KEY decode and the LED outputs. Consumes decoded hits from the keypad controller.
- Replaces the fixed 9-light, fixed-timing light controller path.

---
 rtl/wam_pkg.sv | 55 +++++
 rtl/wam_lfsr.sv | 35 +++
 rtl/wam_game_engine.sv | 177 +++++++++++++++++
 tb/tb_wam_game_engine.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wam_pkg.sv
// Shared types and constants for the whack-a-mole game core.
package wam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2,
    ST_DONE = 2'd3
  } wam_state_e;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_TIMED  = 2'd1;
  localparam logic [1:0] MODE_DEATH  = 2'd2;
  localparam logic [1:0] MODE_CONT   = 2'd3;

  localparam logic [5:0] FLICKS_STD = 6'd25;
  localparam logic [5:0] FLICKS_EXT = 6'd50;
  localparam int         CONT_STEP  = 8;

  function automatic logic [3:0] gap_ticks(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return 4'd8;
      2'd1:    return 4'd4;
      2'd2:    return 4'd2;
      default: return 4'd1;
    endcase
  endfunction

  function automatic logic [3:0] on_ticks(input logic [1:0] lvl);
    case (lvl)
      2'd0:    return 4'd8;
      2'd1:    return 4'd4;
      2'd2:    return 4'd4;
      default: return 4'd2;
    endcase
  endfunction

  // Maximal-length Galois feedback masks (right-shifting form).
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      4:       return 64'h0000_000C;
      5:       return 64'h0000_0014;
      6:       return 64'h0000_0030;
      7:       return 64'h0000_0060;
      8:       return 64'h0000_00B8;
      10:      return 64'h0000_0240;
      12:      return 64'h0000_0E08;
      20:      return 64'h0009_0000;
      24:      return 64'h00E1_0000;
      32:      return 64'hA300_0000;
      default: return 64'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/wam_lfsr.sv
// Free-running Galois LFSR; loads the seed once on the first request after reset.
module wam_lfsr
  import wam_pkg::*;
#(
  parameter int LFSR_W = 16,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  output logic [OUT_W-1:0]  rnd
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic [LFSR_W-1:0] state_q;
  logic              seeded_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= LFSR_W'(1);
      seeded_q <= 1'b0;
    end else if (load && !seeded_q) begin
      // An all-zero state would lock the generator up.
      state_q  <= (seed == '0) ? LFSR_W'(1) : seed;
      seeded_q <= 1'b1;
    end else begin
      state_q  <= {1'b0, state_q[LFSR_W-1:1]} ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign rnd = state_q[OUT_W-1:0];

endmodule

// File: rtl/wam_game_engine.sv
// Whack-a-mole game core: mole sequencing, timing, scoring and game modes.
// Optional build macro WAM_NO_REPEAT_EN forbids the same mole lighting twice in a row.
module wam_game_engine
  import wam_pkg::*;
#(
  parameter int  NUM_MOLES   = 9,
  parameter int  TICK_DIV    = 12_500_000,
  parameter int  TIMED_TICKS = 240,
  parameter int  LFSR_W      = 16,
  parameter int  SCORE_W     = 7,
  localparam int IDX_W       = $clog2(NUM_MOLES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [1:0]           level,
  input  logic                 extended,
  input  logic [LFSR_W-1:0]    seed,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_idx,
  output logic [NUM_MOLES-1:0] lights,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [1:0]           cur_level,
  output logic                 busy,
  output logic                 game_over
);

  localparam int PR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GT_W = $clog2(TIMED_TICKS + 1);

  wam_state_e         state_q, state_d;
  logic [PR_W-1:0]    presc_q;
  logic               tick;
  logic [3:0]         tmr_q;
  logic [GT_W-1:0]    gtick_q;
  logic [5:0]         flicks_q, flick_lim;
  logic [1:0]         mode_q, lvl_q;
  logic               ext_q;
  logic [SCORE_W-1:0] score_q, misses_q;
  logic [IDX_W-1:0]   mole_q, rnd, pick, sel;
  logic               ev_hit, ev_miss, ev_flick, latch, tmr_clr, tmr_inc;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  wam_lfsr #(.LFSR_W(LFSR_W), .OUT_W(IDX_W)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .seed  (seed),
    .rnd   (rnd)
  );

  // Out-of-range candidates fold down by NUM_MOLES; the low bits of the
  // modular difference are already the folded index.
  assign pick = ({1'b0, rnd} >= (IDX_W+1)'(NUM_MOLES)) ? rnd - IDX_W'(NUM_MOLES) : rnd;

`ifdef WAM_NO_REPEAT_EN
  always_comb begin
    sel = pick;
    if (pick == mole_q)
      sel = (pick == IDX_W'(NUM_MOLES - 1)) ? '0 : pick + IDX_W'(1);
  end
`else
  assign sel = pick;
`endif

  assign tick      = (presc_q == PR_W'(TICK_DIV - 1));
  assign flick_lim = ext_q ? FLICKS_EXT : FLICKS_STD;
  assign busy      = (state_q == ST_GAP) || (state_q == ST_SHOW);
  assign game_over = (state_q == ST_DONE);
  assign lights    = (state_q == ST_SHOW) ? (NUM_MOLES'(1) << mole_q) : '0;
  assign score     = score_q;
  assign misses    = misses_q;
  assign cur_level = lvl_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ev_hit   = 1'b0;
    ev_miss  = 1'b0;
    ev_flick = 1'b0;
    latch    = 1'b0;
    tmr_clr  = 1'b0;
    tmr_inc  = 1'b0;
    case (state_q)
      ST_GAP: begin
        if (tick) begin
          if (tmr_q == gap_ticks(lvl_q) - 4'd1) begin
            latch   = 1'b1;
            tmr_clr = 1'b1;
            state_d = ST_SHOW;
          end else begin
            tmr_inc = 1'b1;
          end
        end
      end
      ST_SHOW: begin
        // A correct hit wins over a simultaneous timeout.
        if (hit_valid && hit_idx == mole_q) begin
          ev_hit   = 1'b1;
          ev_flick = 1'b1;
          tmr_clr  = 1'b1;
          state_d  = ST_GAP;
        end else if (tick && tmr_q == on_ticks(lvl_q) - 4'd1) begin
          ev_miss  = 1'b1;
          ev_flick = 1'b1;
          tmr_clr  = 1'b1;
          state_d  = (mode_q == MODE_DEATH) ? ST_DONE : ST_GAP;
        end else begin
          if (hit_valid) begin
            ev_miss = 1'b1;
            if (mode_q == MODE_DEATH) state_d = ST_DONE;
          end
          if (tick) tmr_inc = 1'b1;
        end
      end
      default: ;
    endcase
    if (ev_flick && mode_q != MODE_TIMED && (flicks_q + 6'd1) == flick_lim)
      state_d = ST_DONE;
    if (busy && tick && mode_q == MODE_TIMED && gtick_q == GT_W'(TIMED_TICKS - 1))
      state_d = ST_DONE;
    if (start)
      state_d = ST_GAP;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q  <= '0;
      tmr_q    <= '0;
      gtick_q  <= '0;
      flicks_q <= '0;
      mode_q   <= MODE_NORMAL;
      lvl_q    <= 2'd0;
      ext_q    <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      presc_q <= (start || tick) ? '0 : presc_q + PR_W'(1);
      if (start) begin
        tmr_q    <= '0;
        gtick_q  <= '0;
        flicks_q <= '0;
        score_q  <= '0;
        misses_q <= '0;
        mode_q   <= mode;
        ext_q    <= extended;
        lvl_q    <= (mode == MODE_CONT) ? 2'd0 : level;
      end else begin
        if (tmr_clr)      tmr_q <= '0;
        else if (tmr_inc) tmr_q <= tmr_q + 4'd1;
        if (busy && tick) gtick_q <= gtick_q + GT_W'(1);
        if (ev_flick)     flicks_q <= flicks_q + 6'd1;
        if (ev_miss)      misses_q <= sat_inc(misses_q);
        if (ev_hit) begin
          score_q <= sat_inc(score_q);
          // score_q still holds the pre-hit count, so this fires on every CONT_STEP-th hit.
          if (mode_q == MODE_CONT && score_q[2:0] == 3'(CONT_STEP - 1) && lvl_q != 2'd3)
            lvl_q <= lvl_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (latch) mole_q <= sel;
  end

endmodule

// File: tb/tb_wam_game_engine.sv
// Directed, table-driven bench for wam_game_engine (9-mole core plus a 5-mole instance).
module tb_wam_game_engine;

  localparam int NM  = 9;
  localparam int IW  = 4;
  localparam int NMB = 5;
  localparam int IWB = 3;
  localparam int NV  = 10;

  logic           clk = 1'b0;
  logic           reset, start, start_b, extended, hit_valid;
  logic [1:0]     mode, level;
  logic [15:0]    seed;
  logic [IW-1:0]  hit_idx;
  logic [NM-1:0]  lights;
  logic [6:0]     score, misses;
  logic [1:0]     cur_level;
  logic           busy, game_over;

  logic           hit_valid_b = 1'b0;
  logic [IWB-1:0] hit_idx_b = '0;
  logic [NMB-1:0] lights_b;
  logic [6:0]     score_b, misses_b;
  logic [1:0]     cur_level_b;
  logic           busy_b, game_over_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wam_game_engine #(.NUM_MOLES(NM), .TICK_DIV(4), .TIMED_TICKS(20), .LFSR_W(16), .SCORE_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .level(level), .extended(extended),
    .seed(seed), .hit_valid(hit_valid), .hit_idx(hit_idx), .lights(lights), .score(score),
    .misses(misses), .cur_level(cur_level), .busy(busy), .game_over(game_over)
  );

  wam_game_engine #(.NUM_MOLES(NMB), .TICK_DIV(2), .TIMED_TICKS(20), .LFSR_W(16), .SCORE_W(7)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode), .level(level), .extended(extended),
    .seed(seed), .hit_valid(hit_valid_b), .hit_idx(hit_idx_b), .lights(lights_b), .score(score_b),
    .misses(misses_b), .cur_level(cur_level_b), .busy(busy_b), .game_over(game_over_b)
  );

  typedef struct {
    logic [1:0] mode;
    logic [1:0] level;
    logic       ext;
    int         n;
    int         pat;      // 0 all hits, 1 hit on even flicks, 2 hits then final timeout
    int         e_score;
    int         e_miss;
    logic       e_over;
    logic [1:0] e_lvl;
  } vec_t;

  vec_t vecs[NV];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [NM-1:0] l);
    int r = 0;
    for (int i = 0; i < NM; i++) if (l[i]) r = i;
    return r;
  endfunction

  function automatic int idx_of_b(input logic [NMB-1:0] l);
    int r = 0;
    for (int i = 0; i < NMB; i++) if (l[i]) r = i;
    return r;
  endfunction

  task automatic do_start(input logic [1:0] m, input logic [1:0] l, input logic e);
    @(negedge clk);
    mode = m; level = l; extended = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_mole(output int idx, output bit ok);
    ok = 1'b0;
    idx = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lights != '0) begin
        ok = 1'b1;
        idx = idx_of(lights);
        break;
      end
    end
  endtask

  task automatic wait_dark(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (lights == '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic press(input int idx);
    hit_valid = 1'b1;
    hit_idx   = IW'(idx);
    @(negedge clk);
    hit_valid = 1'b0;
  endtask

  initial begin
    int  idx, prev_idx, seen;
    bit  ok, hit;
    logic [NMB-1:0] prev_l;

    vecs[0] = '{2'd0, 2'd3, 1'b0, 25, 0, 25,  0, 1'b1, 2'd3};
    vecs[1] = '{2'd0, 2'd3, 1'b1, 50, 0, 50,  0, 1'b1, 2'd3};
    vecs[2] = '{2'd0, 2'd2, 1'b0, 10, 0, 10,  0, 1'b0, 2'd2};
    vecs[3] = '{2'd0, 2'd3, 1'b0, 25, 1, 13, 12, 1'b1, 2'd3};
    vecs[4] = '{2'd2, 2'd3, 1'b0,  6, 2,  5,  1, 1'b1, 2'd3};
    vecs[5] = '{2'd3, 2'd2, 1'b0,  8, 0,  8,  0, 1'b0, 2'd1};
    vecs[6] = '{2'd3, 2'd1, 1'b0, 16, 0, 16,  0, 1'b0, 2'd2};
    vecs[7] = '{2'd3, 2'd0, 1'b0, 24, 0, 24,  0, 1'b0, 2'd3};
    vecs[8] = '{2'd3, 2'd3, 1'b1, 32, 0, 32,  0, 1'b0, 2'd3};
    vecs[9] = '{2'd3, 2'd0, 1'b0, 25, 0, 25,  0, 1'b1, 2'd3};

    reset = 1'b0; start = 1'b0; start_b = 1'b0; mode = 2'd0; level = 2'd0;
    extended = 1'b0; seed = 16'hACE1; hit_valid = 1'b0; hit_idx = '0;
    repeat (3) @(negedge clk);
    chk("rst_lights", lights, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_level", cur_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    reset = 1'b1;
    @(negedge clk);

    // Gap/show timing, level 1 with 4 clk per tick
    do_start(2'd0, 2'd1, 1'b0);
    chk("gap_busy", busy, 1);
    repeat (15) @(negedge clk);
    chk("gap_dark_15", lights, 0);
    @(negedge clk);
    chk("mole_onehot_16", $onehot(lights), 1);
    repeat (15) @(negedge clk);
    chk("show_lit_31", $onehot(lights), 1);
    @(negedge clk);
    chk("timeout_dark_32", lights, 0);
    chk("timeout_miss", misses, 1);

    // Deathmatch wrong press ends the game
    do_start(2'd2, 2'd0, 1'b0);
    wait_mole(idx, ok);
    chk("dm_mole_seen", ok, 1);
    press((idx + 1) % NM);
    chk("dm_misses", misses, 1);
    chk("dm_over", game_over, 1);
    chk("dm_lights", lights, 0);
    chk("dm_score", score, 0);

    // Timed expiry: 20 ticks * 4 clk, 6 timeouts at level 3
    do_start(2'd1, 2'd3, 1'b0);
    repeat (79) @(negedge clk);
    chk("timed_run_79", game_over, 0);
    @(negedge clk);
    chk("timed_over_80", game_over, 1);
    chk("timed_misses", misses, 6);

    // Hit on the expiry edge still scores
    do_start(2'd1, 2'd3, 1'b0);
    repeat (79) @(negedge clk);
    chk("timed_lit_79", $onehot(lights), 1);
    press(idx_of(lights));
    chk("timed_hit_score", score, 1);
    chk("timed_hit_over", game_over, 1);
    chk("timed_hit_misses", misses, 6);

    // Presses outside SHOW are ignored; restart mid-SHOW clears counters
    do_start(2'd0, 2'd1, 1'b0);
    wait_mole(idx, ok);
    press(idx);
    chk("ms_score", score, 1);
    press(0);
    chk("gap_press_ignored", misses, 0);
    wait_mole(idx, ok);
    press((idx + 1) % NM);
    chk("wrong_miss", misses, 1);
    chk("wrong_stays_show", lights != '0, 1);
    do_start(2'd0, 2'd1, 1'b0);
    chk("restart_score", score, 0);
    chk("restart_misses", misses, 0);
    chk("restart_lights", lights, 0);
    chk("restart_busy", busy, 1);

    for (int v = 0; v < NV; v++) begin
      do_start(vecs[v].mode, vecs[v].level, vecs[v].ext);
      chk("start_level", cur_level, (vecs[v].mode == 2'd3) ? 0 : vecs[v].level);
      for (int f = 0; f < vecs[v].n; f++) begin
        wait_mole(idx, ok);
        if (!ok) begin
          chk("vec_mole_wait", 0, 1);
          break;
        end
        hit = (vecs[v].pat == 0) || (vecs[v].pat == 1 && f % 2 == 0) ||
              (vecs[v].pat == 2 && f != vecs[v].n - 1);
        if (hit) press(idx);
        else begin
          wait_dark(ok);
          if (!ok) chk("vec_dark_wait", 0, 1);
        end
      end
      chk($sformatf("vec%0d_score", v), score, vecs[v].e_score);
      chk($sformatf("vec%0d_misses", v), misses, vecs[v].e_miss);
      chk($sformatf("vec%0d_over", v), game_over, vecs[v].e_over);
      chk($sformatf("vec%0d_level", v), cur_level, vecs[v].e_lvl);
    end

    // Five-mole instance: every lit pattern must be one-hot over 50 timeouts
    @(negedge clk);
    mode = 2'd0; level = 2'd3; extended = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    prev_l = '0; prev_idx = -1; seen = 0;
    for (int i = 0; i < 800 && !game_over_b; i++) begin
      @(negedge clk);
      if (lights_b != '0 && prev_l == '0) begin
        seen++;
        idx = idx_of_b(lights_b);
        chk("b_onehot", $onehot(lights_b), 1);
`ifdef WAM_NO_REPEAT_EN
        chk("b_no_repeat", idx != prev_idx, 1);
`endif
        prev_idx = idx;
      end
      prev_l = lights_b;
    end
    chk("b_over", game_over_b, 1);
    chk("b_misses", misses_b, 50);
    chk("b_moles_seen", seen, 50);
    chk("b_score", score_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
